stream_demux: RTL and testbench

//   Registered 1-to-N stream demultiplexer; counterpart of the registered 2:1 mux on the datapath.

---
 rtl/demux_pkg.sv | 11 +
 rtl/demux_slot.sv | 34 +++
 rtl/stream_demux.sv | 85 ++++++++
 tb/tb_stream_demux.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered stream demultiplexer.
package demux_pkg;

    typedef enum logic {IDLE, PKT} demux_state_t;

    // Select width for N destinations; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slot with valid/ready handshake and same-cycle drain/refill.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] data,
    input  logic             last,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    output logic             free
);

    // A full slot is reusable in the same cycle it is drained.
    assign free = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (ld) begin
            out_data  <= data;
            out_last  <= last;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demux: selection locks on a packet's head beat and holds to its last beat.
module stream_demux
    import demux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_OUT = 2,
    parameter  int CNT_W = 16,
    localparam int SEL_W = sel_width(N_OUT)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_last,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [N_OUT-1:0][WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]            out_last,
    output logic [N_OUT-1:0]            out_valid,
    input  logic [N_OUT-1:0]            out_ready,
    output logic [CNT_W-1:0]            drop_cnt
);

    demux_state_t     state, state_nxt;
    logic [SEL_W-1:0] locked_sel, locked_sel_nxt;
    logic [SEL_W-1:0] dest;
    logic             dest_ok;
    logic             accept;
    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] ld;

    assign dest    = (state == PKT) ? locked_sel : in_sel;
    assign dest_ok = int'(dest) < N_OUT;
    // Out-of-range destinations are always accepted so the packet can be discarded.
    assign in_ready = dest_ok ? free[dest] : 1'b1;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            locked_sel <= '0;
        end else begin
            state      <= state_nxt;
            locked_sel <= locked_sel_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        locked_sel_nxt = locked_sel;
        case (state)
            IDLE: if (accept && !in_last) begin
                state_nxt      = PKT;
                locked_sel_nxt = in_sel;
            end
            PKT: if (accept && in_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_cnt <= '0;
        else if (accept && !dest_ok && drop_cnt != {CNT_W{1'b1}})
            drop_cnt <= drop_cnt + 1'b1;
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        assign ld[k] = accept & dest_ok & (dest == SEL_W'(k));

        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .ld        (ld[k]),
            .data      (in_data),
            .last      (in_last),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k]),
            .out_last  (out_last[k]),
            .out_valid (out_valid[k]),
            .free      (free[k])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux (2-output and 3-output instances).
module tb_stream_demux;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [7:0]      in_data = '0;
    logic [0:0]      in_sel = '0;
    logic            in_last = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0][7:0] out_data;
    logic [1:0]      out_last;
    logic [1:0]      out_valid;
    logic [1:0]      out_ready = 2'b11;
    logic [15:0]     drop_cnt;

    logic [7:0]      in_data3 = '0;
    logic [1:0]      in_sel3 = '0;
    logic            in_last3 = 1'b0;
    logic            in_valid3 = 1'b0;
    logic            in_ready3;
    logic [2:0][7:0] out_data3;
    logic [2:0]      out_last3;
    logic [2:0]      out_valid3;
    logic [2:0]      out_ready3 = 3'b111;
    logic [15:0]     drop_cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_demux #(.WIDTH(8), .N_OUT(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
    );

    stream_demux #(.WIDTH(8), .N_OUT(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_sel(in_sel3), .in_last(in_last3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3), .out_last(out_last3),
        .out_valid(out_valid3), .out_ready(out_ready3), .drop_cnt(drop_cnt3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_ready = 2'b00;
        in_sel = 1'b1; in_data = 8'h55; in_last = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 2'b10) begin
            n_bad++; $display("FAIL reset_pre out_valid got %b want %b", out_valid, 2'b10);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 2'b00 || out_data !== 16'h0000 || out_last !== 2'b00) begin
            n_bad++; $display("FAIL reset_async outputs got v=%b d=%h l=%b want 0/0/0",
                              out_valid, out_data, out_last);
        end
        n_cmp++;
        if (drop_cnt !== 16'd0 || drop_cnt3 !== 16'd0) begin
            n_bad++; $display("FAIL reset_drop got %h/%h want 0", drop_cnt, drop_cnt3);
        end
        step();
        reset = 1'b1;
        out_ready = 2'b11;
        step();
    endtask

    task automatic test_back_to_back();
        in_sel = 1'b0; in_data = 8'h11; in_last = 1'b1; in_valid = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready0 got %b want 1", in_ready);
        end
        step();
        in_sel = 1'b1; in_data = 8'h22;
        n_cmp++;
        if (out_valid !== 2'b01 || out_data[0] !== 8'h11 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_beat0 got v=%b d0=%h rdy=%b want 01/11/1",
                              out_valid, out_data[0], in_ready);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 2'b10 || out_data[1] !== 8'h22 || out_data[0] !== 8'h11) begin
            n_bad++; $display("FAIL b2b_beat1 got v=%b d1=%h d0=%h want 10/22/11",
                              out_valid, out_data[1], out_data[0]);
        end
        step();
        n_cmp++;
        if (out_valid !== 2'b00) begin
            n_bad++; $display("FAIL b2b_drain got %b want 00", out_valid);
        end
    endtask

    task automatic test_packet_lock();
        in_sel = 1'b1; in_data = 8'hA1; in_last = 1'b0; in_valid = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 2'b10 || out_data[1] !== 8'hA1 || out_last[1] !== 1'b0) begin
            n_bad++; $display("FAIL lock_a1 got v=%b d=%h l=%b want 10/a1/0",
                              out_valid, out_data[1], out_last[1]);
        end
        in_sel = 1'b0; in_data = 8'hA2;
        step();
        n_cmp++;
        if (out_valid !== 2'b10 || out_data[1] !== 8'hA2 || out_last[1] !== 1'b0) begin
            n_bad++; $display("FAIL lock_a2 got v=%b d=%h l=%b want 10/a2/0",
                              out_valid, out_data[1], out_last[1]);
        end
        in_data = 8'hA3; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++;
        if (out_valid !== 2'b10 || out_data[1] !== 8'hA3 || out_last[1] !== 1'b1) begin
            n_bad++; $display("FAIL lock_a3 got v=%b d=%h l=%b want 10/a3/1",
                              out_valid, out_data[1], out_last[1]);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 2'b10;
        in_sel = 1'b0; in_data = 8'hB1; in_last = 1'b0; in_valid = 1'b1;
        step();
        // Packet to dest 0 is now locked and slot 0 is full; in_sel=1 must be ignored.
        in_sel = 1'b1; in_data = 8'hB2; in_last = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_blocked got in_ready=%b want 0", in_ready);
        end
        step();
        n_cmp++;
        if (out_valid !== 2'b01 || out_data[0] !== 8'hB1 || out_last[0] !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_hold got v=%b d=%h l=%b rdy=%b want 01/b1/0/0",
                              out_valid, out_data[0], out_last[0], in_ready);
        end
        out_ready = 2'b11;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_release got in_ready=%b want 1", in_ready);
        end
        step();
        in_sel = 1'b1; in_data = 8'hC1; in_last = 1'b1;
        n_cmp++;
        if (out_valid !== 2'b01 || out_data[0] !== 8'hB2 || out_last[0] !== 1'b1 || out_data[1] !== 8'hA3) begin
            n_bad++; $display("FAIL bp_refill got v=%b d0=%h l0=%b d1=%h want 01/b2/1/a3",
                              out_valid, out_data[0], out_last[0], out_data[1]);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 2'b10 || out_data[1] !== 8'hC1) begin
            n_bad++; $display("FAIL bp_next got v=%b d1=%h want 10/c1", out_valid, out_data[1]);
        end
        step();
    endtask

    task automatic test_reset_midpacket();
        in_sel = 1'b1; in_data = 8'hD1; in_last = 1'b0; in_valid = 1'b1;
        step();
        in_data = 8'hD2;
        step();
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 2'b00) begin
            n_bad++; $display("FAIL midrst_clear got %b want 00", out_valid);
        end
        step();
        reset = 1'b1;
        in_sel = 1'b0; in_data = 8'hE1; in_last = 1'b0; in_valid = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 2'b01 || out_data[0] !== 8'hE1) begin
            n_bad++; $display("FAIL midrst_head got v=%b d0=%h want 01/e1", out_valid, out_data[0]);
        end
        in_sel = 1'b1; in_data = 8'hE2; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++;
        if (out_valid !== 2'b01 || out_data[0] !== 8'hE2 || out_last[0] !== 1'b1) begin
            n_bad++; $display("FAIL midrst_lock got v=%b d0=%h l0=%b want 01/e2/1",
                              out_valid, out_data[0], out_last[0]);
        end
        n_cmp++;
        if (drop_cnt !== 16'd0) begin
            n_bad++; $display("FAIL n2_drop got %h want 0", drop_cnt);
        end
        step();
    endtask

    task automatic test_discard();
        in_sel3 = 2'd3; in_data3 = 8'h99; in_last3 = 1'b0; in_valid3 = 1'b1;
        #1;
        n_cmp++;
        if (in_ready3 !== 1'b1) begin
            n_bad++; $display("FAIL disc_ready got %b want 1", in_ready3);
        end
        // Beats 2-4 present a valid in_sel that must be ignored under the lock.
        step();
        in_sel3 = 2'd0;
        step();
        step();
        in_last3 = 1'b1;
        step();
        in_valid3 = 1'b0;
        n_cmp++;
        if (drop_cnt3 !== 16'd4 || out_valid3 !== 3'b000) begin
            n_bad++; $display("FAIL disc_count got cnt=%0d v=%b want 4/000", drop_cnt3, out_valid3);
        end
        in_sel3 = 2'd3; in_valid3 = 1'b1;
        repeat (65531) @(posedge clk);
        #1;
        n_cmp++;
        if (drop_cnt3 !== 16'hFFFF) begin
            n_bad++; $display("FAIL disc_max got %h want ffff", drop_cnt3);
        end
        repeat (5) @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        n_cmp++;
        if (drop_cnt3 !== 16'hFFFF || out_valid3 !== 3'b000) begin
            n_bad++; $display("FAIL disc_sat got cnt=%h v=%b want ffff/000", drop_cnt3, out_valid3);
        end
    endtask

    initial begin
        step();
        step();
        reset = 1'b1;
        step();
        test_reset();
        test_back_to_back();
        test_packet_lock();
        test_backpressure();
        test_reset_midpacket();
        test_discard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
